mux_2x1_reg: RTL and testbench
==============================

Name: mux_2x1_reg

Overview:
- Parameterised 2:1 data selector for the microwave timer-input-control path.
- Chooses between two input sources (for example keypad digit or preset value) with a single select line.
- Provides the combinational selected value, plus a registered copy with a valid flag and a select-change strobe for the downstream timer logic.

Parameters:
- WIDTH, 1, bit width of i0, i1, f and q (legal range 1 to 32).

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  register load enable for q
- sel  input  1  source select: 0 selects i0, 1 selects i1
- i0  input  WIDTH  data source 0
- i1  input  WIDTH  data source 1
- f  output  WIDTH  combinational selected data
- q  output  WIDTH  registered selected data
- q_valid  output  1  q holds at least one loaded sample since reset
- sel_changed  output  1  one-cycle strobe: sel differs from its previous sampled value

Behaviour:
- Combinational output f:
  - f = i0 when sel=0; f = i1 when sel=1.
  - Zero latency, no clock involvement, valid during reset.
  - f must track i0, i1 and sel changes immediately in simulation (no delta-cycle glitches beyond one).
- Registered data q:
  - On a rising clk edge with en=1, q <= f. With en=0, q holds.
  - Latency from input to q is one cycle.
- q_valid:
  - Set at the first rising edge with en=1 after reset.
  - Stays 1 until the next reset; it is never cleared by en=0.
- Select tracking:
  - Internal register sel_q <= sel on every rising edge, regardless of en.
  - sel_changed <= (sel != sel_q) on every rising edge, so it is high for exactly one cycle per sampled transition.
  - Back-to-back toggles every cycle give sel_changed high continuously.
- Reset:
  - rst_n low asynchronously forces q=0, q_valid=0, sel_q=0 and sel_changed=0, without waiting for a clock edge.
  - Reset asserted mid-operation clears these registers immediately; f is unaffected.
  - Deassertion is synchronous to clk by system convention. The first edge after release behaves normally; a sel=1 at that first edge produces sel_changed=1 because sel_q reset to 0.
- Simultaneous events:
  - A sel change and en=1 at the same edge load q with the value selected by the new sel.
  - sel_changed asserts on that same edge.
- Width rules: all data paths are exactly WIDTH bits, with no extension or truncation.
- Inputs with X or Z on sel drive f to X in simulation; no special handling in RTL.

Decomposition:
- No shared package is required; WIDTH is the only configuration item.
- Natural sub-module: mux_2x1_comb, the purely combinational WIDTH-bit selector producing f. It is instantiated once.
- The top level adds the q, q_valid, sel_q and sel_changed registers.

Test Plan:
- WIDTH=1, sel=0, sweep (i0,i1) = 00, 01, 10, 11 with 10 ns steps -> f = 0, 0, 1, 1.
- WIDTH=1, sel=1, same sweep -> f = 0, 1, 0, 1. With en=1, q equals the previous cycle's f; q_valid=1 from the first enabled edge.
- Select change: sel 0 -> 1 at an edge -> sel_changed=1 for exactly one cycle, then 0 while sel is held. Toggling sel every cycle -> sel_changed stays 1.
- Enable gating: WIDTH=8, i0=8'h3C, i1=8'hA5, sel=1, en=1 -> q=8'hA5. Then en=0, sel=0 -> f=8'h3C while q holds 8'hA5.
- Asynchronous reset mid-run: with q=8'hA5 and q_valid=1, pull rst_n low between clock edges -> q=0, q_valid=0 and sel_changed=0 immediately; f unchanged. Release, then one enabled edge -> q_valid=1.
- Simultaneous event: sel changes 0 -> 1 at an edge with en=1, i0=8'h01, i1=8'h02 -> q=8'h02 and sel_changed=1 on the same edge.

Source files
------------

// File: rtl/mux_2x1_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_reg_pkg
// Brief    : Shared constants and helpers for the timer-input 2:1 selector.
// Revision : 1.0  initial release
// ============================================================================
package mux_2x1_reg_pkg;

  // Supported data-path width range for the selector.
  localparam int unsigned MUX_WIDTH_MIN = 1;
  localparam int unsigned MUX_WIDTH_MAX = 32;

  // True when the requested width lies inside the supported range.
  function automatic bit mux_width_legal(input int unsigned w);
    return (w >= MUX_WIDTH_MIN) && (w <= MUX_WIDTH_MAX);
  endfunction

endpackage : mux_2x1_reg_pkg
`default_nettype wire

// File: rtl/mux_2x1_comb.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_comb
// Brief    : Purely combinational WIDTH-bit 2:1 selector (sel=0 -> i0).
// Revision : 1.0  initial release
// ============================================================================
module mux_2x1_comb #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] f
);

  // Zero-latency select; an unknown sel propagates as X in simulation.
  assign f = sel ? i1 : i0;

endmodule : mux_2x1_comb
`default_nettype wire

// File: rtl/mux_2x1_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_reg
// Brief    : 2:1 selector for the microwave timer-input path. Provides the
//            combinational selection f, a registered copy q with a sticky
//            valid flag, and a one-cycle strobe on every sampled sel change.
// Revision : 1.0  initial release
// ============================================================================
module mux_2x1_reg
  import mux_2x1_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             sel_changed
);

  // Reject out-of-range widths at elaboration time.
  generate
    if (!mux_width_legal(WIDTH)) begin : g_width_check
      $error("mux_2x1_reg: WIDTH out of supported range");
    end
  endgenerate

  logic [WIDTH-1:0] w_sel_data;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;
  logic             sel_q;
  logic             sel_chg_q;
  logic             sel_chg_d;

  mux_2x1_comb #(
    .WIDTH (WIDTH)
  ) u_mux_2x1_comb (
    .sel (sel),
    .i0  (i0),
    .i1  (i1),
    .f   (w_sel_data)
  );

  // Next-state: load on enable, valid is sticky, strobe compares against last sel.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    sel_chg_d = (sel != sel_q);
    if (en) begin
      data_d  = w_sel_data;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous clear; sel is tracked on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sel_q     <= 1'b0;
      sel_chg_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      sel_q     <= sel;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign f           = w_sel_data;
  assign q           = data_q;
  assign q_valid     = valid_q;
  assign sel_changed = sel_chg_q;

endmodule : mux_2x1_reg
`default_nettype wire

// File: tb/tb_mux_2x1_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2x1_reg
// Brief    : Scoreboard bench for mux_2x1_reg (WIDTH=8) with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_2x1_reg;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             sel;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             sel_changed;

  typedef struct {
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] q;
    logic             v;
    logic             sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  mux_2x1_reg #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sel         (sel),
    .i0          (i0),
    .i1          (i1),
    .f           (f),
    .q           (q),
    .q_valid     (q_valid),
    .sel_changed (sel_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one vector at the falling edge and queue what must be seen after the next rising edge.
  task automatic apply(input logic e, input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] ef,
                       input logic [WIDTH-1:0] eq, input logic ev, input logic esc);
    exp_t x;
    @(negedge clk);
    en = e; sel = s; i0 = a; i1 = b;
    x.f = ef; x.q = eq; x.v = ev; x.sc = esc;
    exp_q.push_back(x);
  endtask

  // Monitor: shortly after each rising edge, compare outputs against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("f",           32'(f),           32'(x.f));
        check("q",           32'(q),           32'(x.q));
        check("q_valid",     32'(q_valid),     32'(x.v));
        check("sel_changed", 32'(sel_changed), 32'(x.sc));
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0; en = 1'b0; sel = 1'b0; i0 = '0; i1 = '0;
    #1;
    check("rst_q",  32'(q),           32'h0);
    check("rst_v",  32'(q_valid),     32'h0);
    check("rst_sc", 32'(sel_changed), 32'h0);
    check("rst_f",  32'(f),           32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //     en    sel   i0     i1     f      q      v     sc
    // sel=0 sweep, no load
    apply(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
    // sel=1 sweep with load; first enabled edge sets valid, sel 0->1 strobes
    apply(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 8'h00, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0);
    // toggle sel each cycle with en=0: strobe stays high, q holds, valid sticky
    apply(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    // enable gating at full width
    apply(1'b1, 1'b1, 8'h3C, 8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 1'b1, 1'b1);

    // asynchronous reset between edges while q=A5, valid=1, strobe=1
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_q",  32'(q),           32'h0);
    check("arst_v",  32'(q_valid),     32'h0);
    check("arst_sc", 32'(sel_changed), 32'h0);
    check("arst_f",  32'(f),           32'h3C);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // after release: no load keeps valid low; then simultaneous sel change + load
    apply(1'b0, 1'b0, 8'h01, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 8'h01, 8'h02, 8'h02, 8'h02, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 8'h01, 8'h02, 8'h02, 8'h02, 1'b1, 1'b0);

    // bounded drain of the scoreboard
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mux_2x1_reg
`default_nettype wire
